// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage of the Filter-GPU core, upstream of control_unit.
//   Owns the program counter and drives a synchronous instruction memory
//   with a one-cycle read latency. It presents a registered instruction,
//   its valid flag and its address to decode. It also handles decode stalls,
//   taken-branch redirects (one bubble) and a HALT word. Once the HALT word
//   is seen, fetch freezes until reset.
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   defined     -> fetch_count counts valid deliveries (saturating)
//   not defined -> fetch_count is tied to 0, no counter logic
//
// Parameters:
//   ADDR_W     instruction-memory word address width (PC wraps mod 2^ADDR_W)
//   INSTR_W    instruction word width
//   RESET_PC   PC loaded on reset
//   HALT_WORD  encoding that halts fetch
//
// Ports:
//   Clock          in   rising-edge clock
//   reset          in   synchronous, active-high
//   stall          in   decode cannot accept; hold outputs
//   branch_taken   in   redirect to branch_target, flush wrong-path word
//   branch_target  in   redirect address
//   imem_addr      out  combinational read address to instruction memory
//   imem_rdata     in   memory data for the address issued last cycle
//   Instr          out  registered instruction to decode
//   InstrValid     out  Instr is a real instruction (not a bubble)
//   InstrPC        out  address of Instr
//   halted         out  fetch frozen by HALT (FSM state visibility)
//   fetch_count    out  valid instructions delivered
//
// Handshake: decode consumes Instr on every edge where InstrValid=1 and
// stall=0. While stall=1 the outputs are held, and the word in flight is
// re-read from memory so that no instruction is lost or duplicated.
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter int                  ADDR_W    = 10,
  parameter int                  INSTR_W   = 28,
  parameter int                  RESET_PC  = 0,
  parameter logic [INSTR_W-1:0]  HALT_WORD = 28'hFFFFFFF
) (
  input  logic               Clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] Instr,
  output logic               InstrValid,
  output logic [ADDR_W-1:0]  InstrPC,
  output logic               halted,
  output logic [31:0]        fetch_count
);

  localparam logic [ADDR_W-1:0] RESET_PC_A = ADDR_W'(RESET_PC);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic                 pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0]    pend_pc_q, pend_pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic                 instr_valid_q, instr_valid_d;
  logic [ADDR_W-1:0]    instr_pc_q, instr_pc_d;

  // Read address. Under stall we re-issue pend_pc so the in-flight word is
  // still on imem_rdata when the stall releases.
  always_comb begin
    imem_addr = pc_q;
    if (reset) begin
      imem_addr = RESET_PC_A;
    end else if (branch_taken && (state_q == RUN)) begin
      imem_addr = branch_target;
    end else if (stall) begin
      imem_addr = pend_pc_q;
    end
  end

  // Next-state / next-register logic
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_pc_d     = pend_pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    instr_pc_d    = instr_pc_q;

    case (state_q)
      RUN: begin
        if (branch_taken) begin
          // Branch wins over stall. The word now arriving is wrong-path,
          // so it is dropped and a bubble goes out.
          pc_d          = branch_target + 1'b1;
          pend_pc_d     = branch_target;
          pend_valid_d  = 1'b1;
          instr_valid_d = 1'b0;
        end else if (!stall) begin
          instr_d       = imem_rdata;
          instr_valid_d = pend_valid_q;
          instr_pc_d    = pend_pc_q;
          pend_pc_d     = pc_q;
          pend_valid_d  = 1'b1;
          pc_d          = pc_q + 1'b1;
          if (pend_valid_q && (imem_rdata == HALT_WORD)) begin
            state_d = HALTED;
          end
        end
      end
      HALTED: begin
        // The HALT word stays visible while decode stalls. It then turns
        // into a bubble for good.
        pend_valid_d = 1'b0;
        if (!stall) begin
          instr_valid_d = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (reset) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC_A;
      pend_valid_q  <= 1'b0;
      pend_pc_q     <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      instr_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_pc_q     <= pend_pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

  assign Instr      = instr_q;
  assign InstrValid = instr_valid_q;
  assign InstrPC    = instr_pc_q;
  assign halted     = (state_q == HALTED);

`ifdef FETCH_PERF_CNT_EN
  logic        load_valid;
  logic [31:0] cnt_q;

  // Only non-stalled, non-branch RUN edges with a real pending word
  // load InstrValid=1.
  assign load_valid = (state_q == RUN) && !branch_taken && !stall && pend_valid_q;

  always_ff @(posedge Clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_valid && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign fetch_count = cnt_q;
`else
  assign fetch_count = '0;
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the Filter-GPU core, sitting directly upstream of `control_unit`. It owns the program counter and drives a synchronous instruction memory with one-cycle read latency. It presents a registered 28-bit instruction word plus valid flag to decode, where `control_unit` consumes `Instr[17:0]`. It handles decode stalls, taken-branch redirects with flush, and a HALT word that freezes fetch until reset.

## Interface
- `ADDR_W`, 10, instruction-memory word address width; PC wraps modulo 2^ADDR_W
- `INSTR_W`, 28, instruction word width
- `RESET_PC`, 0, PC value loaded on reset
- `HALT_WORD`, 28'hFFFFFFF, encoding that halts fetch

- `Clock`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `stall`  in  1  decode cannot accept a new instruction; hold outputs
- `branch_taken`  in  1  redirect fetch to `branch_target`; flush wrong-path word
- `branch_target`  in  ADDR_W  redirect address
- `imem_addr`  out  ADDR_W  combinational read address to instruction memory
- `imem_rdata`  in  INSTR_W  memory data for the address issued the previous cycle
- `Instr`  out  INSTR_W  registered instruction to decode
- `InstrValid`  out  1  `Instr` is a real instruction (not a bubble)
- `InstrPC`  out  ADDR_W  address of `Instr`
- `halted`  out  1  fetch frozen by HALT
- `fetch_count`  out  32  valid instructions delivered (see Configuration)

## Operation
- Registers:
  - `pc` is the next address to issue.
  - `pend_valid` and `pend_pc` describe the word arriving on `imem_rdata` this cycle.
  - Output registers are `Instr`, `InstrValid` and `InstrPC`.
  - State is RUN or HALTED.
- `imem_addr` selection, highest priority first:
  - `branch_target` when `branch_taken` and RUN.
  - Otherwise `pend_pc` when `stall`. This re-reads the in-flight word so it stays available.
  - Otherwise `pc`.
- RUN, `branch_taken`=1 (wins over `stall`):
  - `pc`<=`branch_target`+1, `pend_pc`<=`branch_target`, `pend_valid`<=1.
  - `InstrValid`<=0, `Instr`/`InstrPC` are don't-care.
- RUN, `stall`=1, no branch: `pc`, `pend_*` and all outputs hold.
- RUN, otherwise:
  - `Instr`<=`imem_rdata`, `InstrValid`<=`pend_valid`, `InstrPC`<=`pend_pc`.
  - `pend_pc`<=`pc`, `pend_valid`<=1, `pc`<=`pc`+1.
- RUN→HALTED: the cycle a word equal to `HALT_WORD` is loaded with `InstrValid`<=1.
  - The HALT word is itself delivered once (valid for one cycle, or longer if `stall` is held).
  - On the next non-stalled cycle `InstrValid`<=0.
- HALTED:
  - `pc` and `pend_*` frozen, `pend_valid`<=0, `halted`=1.
  - `branch_taken` and `stall` are ignored; only `reset` exits.
- Simultaneous HALT word and `branch_taken`: the branch flushes the word, so no halt occurs.
- PC arithmetic is unsigned ADDR_W bits. `pc`+1 and `branch_target`+1 wrap from 2^ADDR_W-1 to 0.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `pend_valid`=0, `pend_pc`=0.
  - `Instr`=0, `InstrValid`=0, `InstrPC`=0.
  - `halted`=0, `fetch_count`=0, state RUN.
  - During reset, `imem_addr`=`RESET_PC`.
- Reset asserted mid-operation overrides stall, branch and HALTED in the same edge.
- First valid instruction: `Instr`=mem[`RESET_PC`] with `InstrValid`=1 two edges after reset deasserts. The first post-reset cycle only fills `pend`.
- Steady state: one instruction per cycle; fetch-to-`Instr` latency is 2 cycles.
- Branch in cycle b:
  - Target address issued in b.
  - `InstrValid`=0 in b+1 (one bubble).
  - `Instr`=mem[target] valid in b+2.
- Stall in cycles s..s+k-1: outputs unchanged through s+k. The next instruction appears at edge s+k+1, with no loss or duplication.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `fetch_count` increments on every edge that loads `InstrValid`<=1.
  - It saturates at 32'hFFFFFFFF and clears on reset.
- Not defined: `fetch_count` is tied to 0 and no counter logic is present. The port list is unchanged.

## Test plan
- Sequential fetch: mem[i]=i, reset released → `Instr`=0,1,2,… on consecutive cycles, `InstrPC` matching, `InstrValid`=1 from the 2nd edge.
- Stall: assert `stall` for 3 cycles while `Instr`=5 → `Instr` holds 5; next edge after release gives 6, never 5 twice or 7 skipping 6.
- Branch: `branch_taken`, `branch_target`=0x200 while `Instr`=3 → one cycle `InstrValid`=0, then `InstrPC`=0x200, 0x201; branch with `stall`=1 behaves identically.
- Wrap: `RESET_PC`=1022, ADDR_W=10 → `InstrPC`=1022,1023,0,1.
- HALT: mem[4]=28'hFFFFFFF → `Instr`=HALT_WORD valid once, then `InstrValid`=0 and `halted`=1 indefinitely; branch ignored; `reset` restores fetch from `RESET_PC`.
- Counter (macro on): 10 valid deliveries with 2 bubbles and 3 stall cycles → `fetch_count`=10; macro off → `fetch_count`=0.
